// File: rtl/path_node_sequencer_if.sv
// path_node_sequencer_if: planner request/path-beat bus between the sequencer (master) and the path planner (slave)
interface path_node_sequencer_if #(parameter int NODE_W = 5);
  logic              plan_req;
  logic [NODE_W-1:0] plan_src;
  logic [NODE_W-1:0] plan_dst;
  logic              path_valid;
  logic [NODE_W-1:0] path_node;
  logic              path_last;
  modport master (output plan_req, plan_src, plan_dst, input path_valid, path_node, path_last);
  modport slave (input plan_req, plan_src, plan_dst, output path_valid, path_node, path_last);
endinterface

// File: rtl/path_node_sequencer.sv
// path_node_sequencer: requests a route, buffers it, and steps the bot's logical node position on node-detect pulses
module path_node_sequencer #(
  parameter int                NODE_W    = 5,
  parameter int                MAX_LEN   = 32,
  parameter logic [NODE_W-1:0] HOME_NODE = '0
) (
  input  logic                  clk_3125KHz,
  input  logic                  reset,
  input  logic                  CPU_start,
  input  logic [NODE_W-1:0]     start_point,
  input  logic [NODE_W-1:0]     end_point,
  path_node_sequencer_if.master plan,
  input  logic                  node_detected,
  output logic [NODE_W-1:0]     curr_node,
  output logic [NODE_W-1:0]     next_node,
  output logic                  move_en,
  output logic                  path_done,
  output logic                  plan_err
);
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  typedef enum logic [1:0] {IDLE, REQ, LOAD, FOLLOW} state_t;
  state_t            state, state_n;
  logic [PW-1:0]     wr_ptr, rd_ptr, len;
  logic [NODE_W-1:0] path_buf [MAX_LEN];
  logic              beat, bad, fin, single, hop, last_hop;
  logic [IW-1:0]     rd_nxt;
  always_comb begin
    beat     = state == LOAD && CPU_start && plan.path_valid;
    bad      = beat && (wr_ptr == PW'(MAX_LEN) || (wr_ptr == '0 && plan.path_node != plan.plan_src));
    fin      = beat && !bad && plan.path_last;
    single   = fin && wr_ptr == '0;
    hop      = state == FOLLOW && node_detected;
    last_hop = rd_ptr == len - 1'b1;
    rd_nxt   = IW'(rd_ptr + 1'b1);
    state_n  = state;
    case (state)
      IDLE:    state_n = CPU_start && end_point != curr_node ? REQ : IDLE;
      REQ:     state_n = CPU_start ? LOAD : IDLE;
      LOAD:    state_n = !CPU_start || bad || single ? IDLE : fin ? FOLLOW : LOAD;
      FOLLOW:  state_n = !CPU_start || (hop && last_hop) ? IDLE : FOLLOW;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      plan.plan_req <= 1'b0;
      plan.plan_src <= '0;
      plan.plan_dst <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len           <= '0;
      curr_node     <= HOME_NODE;
      next_node     <= HOME_NODE;
      move_en       <= 1'b0;
      path_done     <= 1'b0;
      plan_err      <= 1'b0;
    end else begin
      state         <= state_n;
      plan.plan_req <= state_n == REQ;
      move_en       <= state_n == FOLLOW;
      path_done     <= single || (hop && last_hop);
      plan_err      <= plan_err || bad;
      if (state == IDLE && state_n == REQ) begin
        plan.plan_src <= start_point;
        plan.plan_dst <= end_point;
      end
      if (state == REQ) wr_ptr <= '0;
      if (beat && !bad) wr_ptr <= wr_ptr + 1'b1;
      // a two-node path writes buf[1] on this very beat, so forward it
      if (fin && !single) begin
        len       <= wr_ptr + 1'b1;
        rd_ptr    <= PW'(1);
        next_node <= wr_ptr == PW'(1) ? plan.path_node : path_buf[1];
      end
      if (hop) begin
        curr_node <= next_node;
        if (!last_hop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          next_node <= path_buf[rd_nxt];
        end
      end
    end
  end
  always_ff @(posedge clk_3125KHz)
    if (beat && !bad) path_buf[IW'(wr_ptr)] <= plan.path_node;
endmodule

// File: tb/tb_path_node_sequencer.sv
// tb_path_node_sequencer: directed goals and planner paths; expected DUT events are queued and checked by a negedge monitor
module tb_path_node_sequencer;
  localparam int EV_REQ = 0, EV_GO = 1, EV_NODE = 2, EV_DONE = 3, EV_ERR = 4;
  typedef struct {int k; int a; int b; int c;} ev_t;
  logic       clk_3125KHz = 1'b0, reset = 1'b1, CPU_start = 1'b0, node_detected = 1'b0;
  logic [4:0] start_point = '0, end_point = '0, curr_node, next_node;
  logic       move_en, path_done, plan_err;
  ev_t        exp_q[$];
  logic [4:0] beats[$];
  int         n_checks = 0, n_fail = 0, prev_curr = 0;
  logic       prev_move = 1'b0, prev_err = 1'b0;
  path_node_sequencer_if #(.NODE_W(5)) bus();
  path_node_sequencer #(.NODE_W(5), .MAX_LEN(32), .HOME_NODE(5'd0)) dut (
    .clk_3125KHz(clk_3125KHz), .reset(reset), .CPU_start(CPU_start),
    .start_point(start_point), .end_point(end_point), .plan(bus),
    .node_detected(node_detected), .curr_node(curr_node), .next_node(next_node),
    .move_en(move_en), .path_done(path_done), .plan_err(plan_err));
  always #5 clk_3125KHz = ~clk_3125KHz;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void push(input int k, input int a, input int b, input int c);
    ev_t e;
    e.k = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction
  task automatic ev_check(input int k, input int a, input int b, input int c);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected event: got k=%0d a=%0d b=%0d c=%0d expected none", k, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.a != a || e.b != b || e.c != c) begin
        n_fail++;
        $display("FAIL event: got k=%0d a=%0d b=%0d c=%0d expected k=%0d a=%0d b=%0d c=%0d",
                 k, a, b, c, e.k, e.a, e.b, e.c);
      end
    end
  endtask
  always @(negedge clk_3125KHz) begin
    if (!reset) begin
      if (bus.plan_req) ev_check(EV_REQ, bus.plan_src, bus.plan_dst, 0);
      if (move_en && !prev_move) ev_check(EV_GO, next_node, curr_node, 0);
      if (curr_node != prev_curr) ev_check(EV_NODE, curr_node, next_node, move_en);
      if (path_done) ev_check(EV_DONE, curr_node, move_en, 0);
      if (plan_err && !prev_err) ev_check(EV_ERR, curr_node, 0, 0);
    end
    prev_curr = curr_node;
    prev_move = move_en;
    prev_err  = plan_err;
  end
  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask
  task automatic go(input logic [4:0] s, input logic [4:0] d);
    start_point = s;
    end_point   = d;
    CPU_start   = 1'b1;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!bus.plan_req && n < 20) begin
      @(negedge clk_3125KHz);
      n++;
    end
    if (!bus.plan_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL plan_req wait: got 0 expected 1 within 20 cycles");
    end
    tick();
  endtask
  task automatic send_beats();
    for (int i = 0; i < beats.size(); i++) begin
      bus.path_valid = 1'b1;
      bus.path_node  = beats[i];
      bus.path_last  = i == beats.size() - 1;
      tick();
    end
    bus.path_valid = 1'b0;
    bus.path_last  = 1'b0;
  endtask
  task automatic pulse();
    node_detected = 1'b1;
    tick();
    node_detected = 1'b0;
  endtask
  task automatic trip(input logic [4:0] s, input logic [4:0] d);
    go(s, d);
    push(EV_REQ, s, d, 0);
    push(EV_GO, d, s, 0);
    wait_req();
    beats = '{s, d};
    send_beats();
    repeat (2) tick();
    push(EV_NODE, d, d, 0);
    push(EV_DONE, d, 0, 0);
    pulse();
    CPU_start = 1'b0;
    repeat (2) tick();
  endtask
  task automatic rst_checks(input string tag);
    chk({tag, " curr_node"}, curr_node, 0);
    chk({tag, " next_node"}, next_node, 0);
    chk({tag, " move_en"}, move_en, 0);
    chk({tag, " plan_req"}, bus.plan_req, 0);
    chk({tag, " path_done"}, path_done, 0);
    chk({tag, " plan_err"}, plan_err, 0);
    chk({tag, " plan_src"}, bus.plan_src, 0);
    chk({tag, " plan_dst"}, bus.plan_dst, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.path_valid = 1'b0;
    bus.path_node  = '0;
    bus.path_last  = 1'b0;
    repeat (2) tick();
    rst_checks("reset");
    reset = 1'b0;
    tick();
    // 0 -> 29 via [0,1,28,29]; last two pulses back to back
    go(0, 29);
    push(EV_REQ, 0, 29, 0);
    push(EV_GO, 1, 0, 0);
    wait_req();
    beats = '{5'd0, 5'd1, 5'd28, 5'd29};
    send_beats();
    repeat (2) tick();
    push(EV_NODE, 1, 28, 1);
    pulse();
    tick();
    push(EV_NODE, 28, 29, 1);
    push(EV_NODE, 29, 29, 0);
    push(EV_DONE, 29, 0, 0);
    pulse();
    pulse();
    repeat (4) tick();
    chk("move_en after done", move_en, 0);
    CPU_start = 1'b0;
    tick();
    // goal equal to current node never requests
    trip(29, 24);
    go(3, 24);
    repeat (6) begin
      tick();
      chk("same-node plan_req", bus.plan_req, 0);
      chk("same-node move_en", move_en, 0);
    end
    CPU_start = 1'b0;
    tick();
    trip(24, 7);
    // source mismatch on beat 0
    go(7, 9);
    push(EV_REQ, 7, 9, 0);
    push(EV_ERR, 7, 0, 0);
    wait_req();
    beats = '{5'd5};
    send_beats();
    CPU_start = 1'b0;
    repeat (3) tick();
    chk("mismatch curr_node", curr_node, 7);
    chk("mismatch plan_err", plan_err, 1);
    chk("mismatch move_en", move_en, 0);
    // reset clears plan_err, then a 33-beat path overflows
    reset = 1'b1;
    @(negedge clk_3125KHz);
    tick();
    reset = 1'b0;
    chk("reset2 plan_err", plan_err, 0);
    chk("reset2 curr_node", curr_node, 0);
    go(0, 3);
    push(EV_REQ, 0, 3, 0);
    push(EV_ERR, 0, 0, 0);
    wait_req();
    beats.delete();
    beats.push_back(5'd0);
    for (int i = 1; i < 33; i++) beats.push_back(5'(i));
    send_beats();
    CPU_start = 1'b0;
    repeat (3) tick();
    chk("overflow move_en", move_en, 0);
    chk("overflow plan_err", plan_err, 1);
    trip(0, 3);
    chk("sticky plan_err", plan_err, 1);
    chk("after-overflow curr_node", curr_node, 3);
    trip(3, 29);
    // abort coinciding with the first node pulse on [29,27,24]
    go(29, 24);
    push(EV_REQ, 29, 24, 0);
    push(EV_GO, 27, 29, 0);
    wait_req();
    beats = '{5'd29, 5'd27, 5'd24};
    send_beats();
    repeat (2) tick();
    push(EV_NODE, 27, 24, 0);
    node_detected = 1'b1;
    CPU_start     = 1'b0;
    tick();
    node_detected = 1'b0;
    repeat (3) tick();
    chk("abort curr_node", curr_node, 27);
    chk("abort move_en", move_en, 0);
    // asynchronous reset while following [27,24]
    go(27, 24);
    push(EV_REQ, 27, 24, 0);
    push(EV_GO, 24, 27, 0);
    wait_req();
    beats = '{5'd27, 5'd24};
    send_beats();
    tick();
    @(negedge clk_3125KHz);
    #2;
    reset     = 1'b1;
    CPU_start = 1'b0;
    #1;
    rst_checks("async reset");
    @(negedge clk_3125KHz);
    tick();
    reset = 1'b0;
    beats = '{5'd27, 5'd24};
    send_beats();
    repeat (4) tick();
    chk("post-reset move_en", move_en, 0);
    chk("post-reset curr_node", curr_node, 0);
    repeat (3) tick();
    chk("events outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
